one_hot_demux_ff: RTL and testbench
===================================

Name: one_hot_demux_ff

Overview:
- Registered one-hot demultiplexer: distributor counterpart of the one-hot mux-with-flop.
- One upstream valid/ready stream carries a data word plus a one-hot destination select.
- Each word is steered into one of CNT per-channel output slots.
- Each slot drains independently through its own valid/ready handshake.
- Non-one-hot selects are dropped, flagged and counted.
- Used wherever a single producer fans out to CNT consumers with independent backpressure.

Parameters:
WIDTH, 32, data word width
CNT, 5, number of output channels; width of the select
ONE_HOT_CHECK, 1, 1 = detect/drop/count illegal selects; 0 = check removed, select guaranteed one-hot by the source
ERR_CNT_W, 8, width of the saturating error counter

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous reset, active-high
in_vld  input  1  upstream word valid
in_sel  input  CNT  one-hot destination select, qualified by in_vld
in_data  input  WIDTH  upstream data word
in_rdy  output  1  upstream ready (combinational)
out_vld  output  CNT  per-channel slot valid (registered)
out_data  output  WIDTH*CNT  per-channel slot data; channel i = bits [i*WIDTH +: WIDTH] (registered)
out_rdy  input  CNT  per-channel downstream ready
err  output  1  one-cycle pulse, illegal select consumed (registered)
err_cnt  output  ERR_CNT_W  saturating count of illegal selects (registered)

Behaviour:
- Reset: while rst is high, asynchronously clear out_vld, out_data, err and err_cnt to 0. Words held in slots at reset are discarded.
- sel_ok = exactly one bit of in_sel set. With ONE_HOT_CHECK=0, sel_ok is treated as constant 1.
- slot_free[i] = !out_vld[i] || out_rdy[i]. A slot draining this cycle may be reloaded this cycle.
- in_rdy:
  - sel_ok: in_rdy = |(in_sel & slot_free).
  - !sel_ok: in_rdy = 1, so an illegal word is always consumed.
  - in_rdy does not depend on in_vld. It may depend on in_sel, which is stable while in_vld is high.
- Accept: in_vld && in_rdy && sel_ok.
  - Next edge: out_vld[i] <= 1 and slice i <= in_data for the selected i.
  - Latency is 1 cycle from accept to out_vld.
- Drain: out_vld[i] && out_rdy[i] with no load into i clears out_vld[i].
  - Slice data is held, not cleared.
  - Data of non-loaded slots never changes.
- Load and drain on the same slot in the same cycle: load wins; out_vld stays 1 with new data. Each channel sustains 1 word/cycle.
- Handshakes on different channels in the same cycle are fully independent.
- Illegal select (in_vld && !sel_ok, including all-zero):
  - No slot is touched.
  - err = 1 on the next cycle only.
  - err_cnt increments by 1 and saturates at 2^ERR_CNT_W-1, with no wrap.
- ONE_HOT_CHECK=0: err and err_cnt are tied to 0. Behaviour with a non-one-hot select is undefined and is not checked.
- No other state; no FSM beyond the per-slot full/empty bit.

Decomposition:
- Shared package one_hot_pkg:
  - function is_one_hot(vector), popcount==1.
  - function sat_inc for the error counter.
  - The existing one-hot mux reuses is_one_hot for its check.
- Sub-module one_hot_demux_slot:
  - One channel's valid bit plus WIDTH data register.
  - Inputs: load, load_data, out_rdy. Outputs: vld, data, free.
  - Instantiated CNT times in a generate loop.
  - Top level holds the select check, in_rdy logic and error counter.

Test Plan:
- Reset with slots full:
  - Load ch0=0xDEADBEEF, then assert rst for 1 cycle asynchronously mid-cycle.
  - Expect out_vld=5'b00000, out_data=0, err_cnt=0 immediately on assertion.
- Single word:
  - in_vld=1, in_sel=5'b00100, in_data=0x12345678, out_rdy=0.
  - Next cycle: out_vld=5'b00100 and slice 2=0x12345678.
  - A second word to ch2 sees in_rdy=0 until out_rdy[2]=1.
- Back-to-back on one channel:
  - 4 consecutive words 1..4 to ch3, out_rdy[3]=1 throughout.
  - Expect in_rdy=1 every cycle and ch3 outputs 1,2,3,4 on consecutive cycles.
- Cross-channel independence:
  - ch1 full with out_rdy[1]=0; send word 0xA5 to ch4.
  - Expect in_rdy=1, ch4 loads, and ch1 data is unchanged.
- Illegal selects:
  - Send in_sel=5'b00110, then 5'b00000.
  - Expect in_rdy=1 both cycles, no out_vld change, err pulsed in each following cycle, err_cnt=2.
- Saturation:
  - ERR_CNT_W=2; send 5 illegal words.
  - Expect err_cnt sequence 1,2,3,3,3 and err pulsing on all 5.

Source files
------------

// File: rtl/one_hot_pkg.sv
// Shared one-hot helpers.
//   is_one_hot : 1 when exactly one bit of the (zero-extended) vector is set.
//   sat_inc    : increment that sticks at the all-ones value of a w-bit field.
// The one-hot mux uses is_one_hot for its select check as well, so any change
// here affects both blocks.
package one_hot_pkg;

  localparam int ONE_HOT_MAX_W = 64;  // widest select the helper accepts
  localparam int SAT_MAX_W     = 32;  // widest counter sat_inc accepts

  function automatic logic is_one_hot(input logic [ONE_HOT_MAX_W-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < ONE_HOT_MAX_W; i++) n += int'(v[i]);
    return (n == 1);
  endfunction

  // w is the real width of the counter held in v; the upper bits of v are 0.
  function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] v,
                                                   input int w);
    logic [SAT_MAX_W-1:0] max_v;
    // For w == SAT_MAX_W the shift yields 0 and the subtraction wraps to all-ones.
    max_v = (SAT_MAX_W'(1) << w) - SAT_MAX_W'(1);
    return (v == max_v) ? v : v + SAT_MAX_W'(1);
  endfunction

endpackage

// File: rtl/one_hot_demux_ff_if.sv
// Bundle for one_hot_demux_ff: upstream valid/ready stream with one-hot select,
// CNT downstream valid/ready slots, and the illegal-select error outputs.
//   slave  : the demux side (consumes in_*, out_rdy; produces the rest)
//   master : the environment side (producer + consumers)
// out_data is [CNT][WIDTH] packed, bit-identical to a flat WIDTH*CNT bus with
// channel i in bits [i*WIDTH +: WIDTH].
interface one_hot_demux_ff_if #(
  parameter int WIDTH     = 32,
  parameter int CNT       = 5,
  parameter int ERR_CNT_W = 8
);
  logic                      in_vld;
  logic [CNT-1:0]            in_sel;
  logic [WIDTH-1:0]          in_data;
  logic                      in_rdy;
  logic [CNT-1:0]            out_vld;
  logic [CNT-1:0][WIDTH-1:0] out_data;
  logic [CNT-1:0]            out_rdy;
  logic                      err;
  logic [ERR_CNT_W-1:0]      err_cnt;

  modport slave (
    input  in_vld, in_sel, in_data, out_rdy,
    output in_rdy, out_vld, out_data, err, err_cnt
  );

  modport master (
    output in_vld, in_sel, in_data, out_rdy,
    input  in_rdy, out_vld, out_data, err, err_cnt
  );
endinterface

// File: rtl/one_hot_demux_slot.sv
// One output channel of the one-hot demux: a full/empty bit plus a data
// register.
//   clk, rst   : clock, async active-high reset (clears vld and data)
//   load       : write load_data this cycle (wins over a concurrent drain)
//   load_data  : word to store
//   out_rdy    : downstream ready for this channel
//   vld, data  : registered slot contents
//   free       : slot can take a word this cycle (empty, or draining now)
module one_hot_demux_slot #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_rdy,
  output logic             vld,
  output logic [WIDTH-1:0] data,
  output logic             free
);

  logic             vld_d,  vld_q;
  logic [WIDTH-1:0] data_d, data_q;

  // Data is only ever written by a load; a drain just drops the valid bit so
  // the last word stays visible on the bus.
  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    if (load) begin
      vld_d  = 1'b1;
      data_d = load_data;
    end else if (vld_q && out_rdy) begin
      vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign vld  = vld_q;
  assign data = data_q;
  assign free = !vld_q || out_rdy;

endmodule

// File: rtl/one_hot_demux_ff.sv
// Registered one-hot demultiplexer. A single upstream valid/ready stream
// carries a word plus a one-hot destination select; the word lands in one of
// CNT output slots, each drained by its own valid/ready handshake.
// Illegal (non-one-hot) selects are swallowed, pulsed on err and counted in a
// saturating err_cnt.
//   clk, rst : clock, async active-high reset
//   bus      : one_hot_demux_ff_if.slave
//              in_vld/in_sel/in_data/in_rdy   upstream stream (in_rdy comb)
//              out_vld/out_data/out_rdy       per-channel slots (registered)
//              err/err_cnt                    illegal-select pulse/count
// With ONE_HOT_CHECK = 0 the source guarantees a one-hot select; the check,
// err and err_cnt are removed (tied to 0).
module one_hot_demux_ff
  import one_hot_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int CNT           = 5,
  parameter bit ONE_HOT_CHECK = 1'b1,
  parameter int ERR_CNT_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  one_hot_demux_ff_if.slave     bus
);

  logic                      sel_ok;
  logic                      accept;
  logic [CNT-1:0]            slot_free;
  logic [CNT-1:0]            slot_load;
  logic [CNT-1:0]            slot_vld;
  logic [CNT-1:0][WIDTH-1:0] slot_data;

  // An illegal select is always taken so a bad word can never stall the
  // producer. in_rdy is deliberately independent of in_vld.
  assign bus.in_rdy = sel_ok ? |(bus.in_sel & slot_free) : 1'b1;
  assign accept     = bus.in_vld && bus.in_rdy && sel_ok;
  assign slot_load  = {CNT{accept}} & bus.in_sel;

  for (genvar i = 0; i < CNT; i++) begin : g_slot
    one_hot_demux_slot #(
      .WIDTH (WIDTH)
    ) u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (slot_load[i]),
      .load_data (bus.in_data),
      .out_rdy   (bus.out_rdy[i]),
      .vld       (slot_vld[i]),
      .data      (slot_data[i]),
      .free      (slot_free[i])
    );
  end

  assign bus.out_vld  = slot_vld;
  assign bus.out_data = slot_data;

  if (ONE_HOT_CHECK) begin : g_chk
    logic                 illegal;
    logic                 err_d, err_q;
    logic [ERR_CNT_W-1:0] err_cnt_d, err_cnt_q;

    // All-zero selects count as illegal too.
    assign sel_ok  = is_one_hot(ONE_HOT_MAX_W'(bus.in_sel));
    assign illegal = bus.in_vld && !sel_ok;

    always_comb begin
      err_d     = illegal;
      err_cnt_d = err_cnt_q;
      if (illegal) err_cnt_d = ERR_CNT_W'(sat_inc(SAT_MAX_W'(err_cnt_q), ERR_CNT_W));
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        err_q     <= 1'b0;
        err_cnt_q <= '0;
      end else begin
        err_q     <= err_d;
        err_cnt_q <= err_cnt_d;
      end
    end

    assign bus.err     = err_q;
    assign bus.err_cnt = err_cnt_q;
  end else begin : g_nochk
    assign sel_ok      = 1'b1;
    assign bus.err     = 1'b0;
    assign bus.err_cnt = '0;
  end

endmodule

// File: tb/tb_one_hot_demux_ff.sv
module tb_one_hot_demux_ff;
  localparam int W    = 32;
  localparam int CNT  = 5;
  localparam int EW   = 8;
  localparam int EW2  = 2;
  localparam int MAX1 = (1 << EW) - 1;
  localparam int MAX2 = (1 << EW2) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  one_hot_demux_ff_if #(.WIDTH(W), .CNT(CNT), .ERR_CNT_W(EW))  bus  ();
  one_hot_demux_ff_if #(.WIDTH(W), .CNT(CNT), .ERR_CNT_W(EW2)) bus2 ();

  // Second instance only exists to observe counter saturation at 2 bits.
  assign bus2.in_vld  = bus.in_vld;
  assign bus2.in_sel  = bus.in_sel;
  assign bus2.in_data = bus.in_data;
  assign bus2.out_rdy = bus.out_rdy;

  one_hot_demux_ff #(.WIDTH(W), .CNT(CNT), .ONE_HOT_CHECK(1'b1), .ERR_CNT_W(EW))
    dut (.clk(clk), .rst(rst), .bus(bus));
  one_hot_demux_ff #(.WIDTH(W), .CNT(CNT), .ONE_HOT_CHECK(1'b1), .ERR_CNT_W(EW2))
    dut2 (.clk(clk), .rst(rst), .bus(bus2));

  int tests = 0;
  int fails = 0;

  // Reference model: per-channel queue of words loaded but not yet drained,
  // and queues of err_cnt values expected on the cycle after each illegal word.
  logic [W-1:0] exp_q [CNT][$];
  int           err_q1[$];
  int           err_q2[$];
  int           err_m1 = 0, err_m2 = 0;
  int           err_last1 = 0, err_last2 = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CNT; i++) exp_q[i].delete();
    err_q1.delete(); err_q2.delete();
    err_m1 = 0; err_m2 = 0; err_last1 = 0; err_last2 = 0;
  endtask

  // Monitor: at each falling edge compare slots and error outputs with the
  // model; a slot presenting data with out_rdy high hands its word off.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < CNT; i++) begin
        if (exp_q[i].size() != 0) begin
          chk($sformatf("out_vld[%0d]", i), 64'(bus.out_vld[i]), 64'(1));
          chk($sformatf("out_data[%0d]", i), 64'(bus.out_data[i]), 64'(exp_q[i][0]));
          if (bus.out_rdy[i]) void'(exp_q[i].pop_front());
        end else begin
          chk($sformatf("out_vld_idle[%0d]", i), 64'(bus.out_vld[i]), 64'(0));
        end
      end
      chk("err", 64'(bus.err), 64'(err_q1.size() != 0));
      if (err_q1.size() != 0) err_last1 = err_q1.pop_front();
      chk("err_cnt", 64'(bus.err_cnt), 64'(err_last1));
      chk("err2", 64'(bus2.err), 64'(err_q2.size() != 0));
      if (err_q2.size() != 0) err_last2 = err_q2.pop_front();
      chk("err_cnt2", 64'(bus2.err_cnt), 64'(err_last2));
    end
  end

  // One cycle of stimulus: drive shortly after the rising edge, check in_rdy
  // after the monitor has retired this cycle's drains, then update the model.
  task automatic drive(input bit v, input logic [CNT-1:0] s, input logic [W-1:0] d,
                       input logic [CNT-1:0] r, output bit acc);
    bit legal, rdy;
    int ch;
    @(posedge clk); #2;
    bus.in_vld = v; bus.in_sel = s; bus.in_data = d; bus.out_rdy = r;
    @(negedge clk); #1;
    legal = ($countones(s) == 1);
    ch = 0;
    for (int i = 0; i < CNT; i++) if (s[i]) ch = i;
    rdy = legal ? (exp_q[ch].size() == 0) : 1'b1;
    chk("in_rdy", 64'(bus.in_rdy), 64'(rdy));
    acc = v && rdy;
    if (v && legal && rdy) exp_q[ch].push_back(d);
    if (v && !legal) begin
      err_m1 = (err_m1 < MAX1) ? err_m1 + 1 : MAX1;
      err_m2 = (err_m2 < MAX2) ? err_m2 + 1 : MAX2;
      err_q1.push_back(err_m1);
      err_q2.push_back(err_m2);
    end
  endtask

  task automatic idle(input logic [CNT-1:0] r, input int n);
    bit a;
    for (int k = 0; k < n; k++) drive(1'b0, '0, '0, r, a);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_out_vld"}, 64'(bus.out_vld), 64'(0));
    for (int i = 0; i < CNT; i++) chk({tag, "_out_data"}, 64'(bus.out_data[i]), 64'(0));
    chk({tag, "_err"}, 64'(bus.err), 64'(0));
    chk({tag, "_err_cnt"}, 64'(bus.err_cnt), 64'(0));
    chk({tag, "_err_cnt2"}, 64'(bus2.err_cnt), 64'(0));
  endtask

  initial begin
    bit a, hold, v;
    logic [CNT-1:0] s, r;
    logic [W-1:0] d;
    bus.in_vld = 1'b0; bus.in_sel = '0; bus.in_data = '0; bus.out_rdy = '0;
    #1;
    chk_reset_vals("por");
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;

    // Single word to ch2, then a second word stalls until ch2 drains.
    drive(1'b1, 5'b00100, 32'h12345678, 5'b00000, a);
    drive(1'b1, 5'b00100, 32'hCAFE0002, 5'b00000, a);
    drive(1'b1, 5'b00100, 32'hCAFE0002, 5'b00000, a);
    drive(1'b1, 5'b00100, 32'hCAFE0002, 5'b00100, a);
    idle(5'b11111, 2);

    // Back-to-back words 1..4 to ch3 with ch3 always ready.
    for (int k = 1; k <= 4; k++) drive(1'b1, 5'b01000, W'(k), 5'b01000, a);
    idle(5'b11111, 2);

    // ch1 held full while ch4 loads.
    drive(1'b1, 5'b00010, 32'h00000011, 5'b00000, a);
    drive(1'b1, 5'b10000, 32'h000000A5, 5'b00000, a);
    idle(5'b00000, 2);
    idle(5'b11111, 2);

    // Illegal selects: two bits set, then none.
    drive(1'b1, 5'b00110, 32'h0BAD0001, 5'b00000, a);
    drive(1'b1, 5'b00000, 32'h0BAD0002, 5'b00000, a);
    idle(5'b00000, 2);
    chk("err_cnt_after_illegal", 64'(bus.err_cnt), 64'(2));

    // Reset while ch0 holds a word, asserted mid-cycle.
    drive(1'b1, 5'b00001, 32'hDEADBEEF, 5'b00000, a);
    @(posedge clk); #2;
    bus.in_vld = 1'b0; bus.in_sel = '0;
    chk("pre_rst_vld0", 64'(bus.out_vld), 64'(5'b00001));
    chk("pre_rst_data0", 64'(bus.out_data[0]), 64'(32'hDEADBEEF));
    #1 rst = 1'b1;
    #1;
    chk_reset_vals("async_rst");
    model_reset();
    @(posedge clk); #3 rst = 1'b0;

    // Saturation of the 2-bit counter: expected 1,2,3,3,3 on the second DUT.
    for (int k = 0; k < 5; k++) drive(1'b1, 5'b11000, W'(k), 5'b00000, a);
    idle(5'b00000, 2);
    chk("sat_err_cnt2", 64'(bus2.err_cnt), 64'(3));

    // Randomized traffic; a stalled legal word is held until accepted.
    hold = 1'b0; v = 1'b0; s = '0; d = '0;
    for (int n = 0; n < 600; n++) begin
      if (!hold) begin
        v = ($urandom_range(0, 9) < 7);
        if ($urandom_range(0, 9) < 8) begin
          s = '0;
          s[$urandom_range(0, CNT - 1)] = 1'b1;
        end else begin
          s = CNT'($urandom);
        end
        d = $urandom;
      end
      r = CNT'($urandom);
      drive(v, s, d, r, a);
      hold = v && !a;
    end

    // Drain everything and confirm the model empties too.
    idle(5'b11111, 3);
    for (int i = 0; i < CNT; i++) chk($sformatf("final_empty[%0d]", i), 64'(exp_q[i].size()), 64'(0));
    chk("final_err_q", 64'(err_q1.size() + err_q2.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
